// File: rtl/riscv_pkg.sv
// Writeback-source codes, multi-cycle slot states and the pending-destination
// tag compare shared by the scheduler and its bench.
package riscv_pkg;

    localparam logic [2:0] SRC_ALU  = 3'd0;
    localparam logic [2:0] SRC_DMEM = 3'd1;
    localparam logic [2:0] SRC_PC4  = 3'd2;
    localparam logic [2:0] SRC_IMM  = 3'd3;
    localparam logic [2:0] SRC_CSR  = 3'd4;
    localparam logic [2:0] SRC_MUL  = 3'd5;
    localparam logic [2:0] SRC_FPU  = 3'd6;

    typedef enum logic [1:0] {SlotIdle, SlotBusy, SlotHold} slot_state_e;

    // Integer x0 is hardwired and never pending; FP f0 is a real register.
    function automatic logic tag_hit(input logic [4:0] idx, input logic fp, input logic pend,
                                     input logic [4:0] tag_rd, input logic tag_fp);
        return pend && (idx == tag_rd) && (fp == tag_fp) && (fp || (idx != 5'd0));
    endfunction

endpackage

// File: rtl/mc_unit_slot.sv
// One outstanding op for a multi-cycle unit: destination tags, result hold
// register and a BUSY watchdog that drops ops the unit never finishes.
module mc_unit_slot
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_fp,
    input  logic            i_we,
    input  logic            i_done,
    input  logic [XLEN-1:0] i_result,
    input  logic            i_retire,
    output logic            o_idle,
    output logic            o_hold,
    output logic [4:0]      o_rd,
    output logic            o_rd_fp,
    output logic            o_we,
    output logic [XLEN-1:0] o_result,
    output logic            o_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    slot_state_e     state_q;
    logic [CntW-1:0] cnt_q;

    assign o_idle    = (state_q == SlotIdle);
    assign o_hold    = (state_q == SlotHold);
    // A done landing on the last BUSY cycle still captures.
    assign o_timeout = (state_q == SlotBusy) && !i_done && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= SlotIdle;
            cnt_q    <= '0;
            o_rd     <= '0;
            o_rd_fp  <= 1'b0;
            o_we     <= 1'b0;
            o_result <= '0;
        end else begin
            case (state_q)
                SlotIdle: begin
                    if (i_start) begin
                        state_q <= SlotBusy;
                        cnt_q   <= '0;
                        o_rd    <= i_rd;
                        o_rd_fp <= i_rd_fp;
                        o_we    <= i_we;
                    end
                end
                SlotBusy: begin
                    if (i_done) begin
                        state_q  <= SlotHold;
                        o_result <= i_result;
                    end else if (o_timeout) begin
                        state_q <= SlotIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                SlotHold: begin
                    if (i_retire) state_q <= SlotIdle;
                end
                default: state_q <= SlotIdle;
            endcase
        end
    end

endmodule

// File: rtl/mc_unit_sched.sv
// Issue/writeback scheduler for the multiplier and FPU: launch gating, RAW/WAW
// interlocks against pending destinations, and oldest-first writeback grant.
module mc_unit_sched
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_issue_valid,
    input  logic [2:0]      i_issue_src,
    input  logic [4:0]      i_issue_rd,
    input  logic            i_issue_rd_fp,
    input  logic            i_issue_reg_write,
    input  logic [14:0]     i_rs_idx,
    input  logic [2:0]      i_rs_used,
    input  logic [2:0]      i_rs_fp,
    input  logic            i_flush,
    output logic            o_issue_stall,
    output logic            o_mul_start,
    input  logic            i_mul_done,
    input  logic [XLEN-1:0] i_mul_result,
    output logic            o_fpu_start,
    input  logic            i_fpu_done,
    input  logic [XLEN-1:0] i_fpu_result,
    input  logic            i_wb_ready,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic            o_wb_fp,
    output logic            o_wb_we,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_timeout
);

    logic            live_q, age_q, timeout_q;
    logic            mul_idle, mul_hold, mul_rd_fp, mul_we, mul_to, mul_pend, grant_mul;
    logic            fpu_idle, fpu_hold, fpu_rd_fp, fpu_we, fpu_to, fpu_pend, grant_fpu;
    logic [4:0]      mul_rd, fpu_rd;
    logic [XLEN-1:0] mul_res, fpu_res;
    logic            raw, waw, unit_busy, launch;

    mc_unit_slot #(.XLEN(XLEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_mul_slot (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (o_mul_start),
        .i_rd     (i_issue_rd),
        .i_rd_fp  (i_issue_rd_fp),
        .i_we     (i_issue_reg_write),
        .i_done   (i_mul_done),
        .i_result (i_mul_result),
        .i_retire (grant_mul && i_wb_ready),
        .o_idle   (mul_idle),
        .o_hold   (mul_hold),
        .o_rd     (mul_rd),
        .o_rd_fp  (mul_rd_fp),
        .o_we     (mul_we),
        .o_result (mul_res),
        .o_timeout(mul_to)
    );

    mc_unit_slot #(.XLEN(XLEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_fpu_slot (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (o_fpu_start),
        .i_rd     (i_issue_rd),
        .i_rd_fp  (i_issue_rd_fp),
        .i_we     (i_issue_reg_write),
        .i_done   (i_fpu_done),
        .i_result (i_fpu_result),
        .i_retire (grant_fpu && i_wb_ready),
        .o_idle   (fpu_idle),
        .o_hold   (fpu_hold),
        .o_rd     (fpu_rd),
        .o_rd_fp  (fpu_rd_fp),
        .o_we     (fpu_we),
        .o_result (fpu_res),
        .o_timeout(fpu_to)
    );

    assign mul_pend = !mul_idle && mul_we;
    assign fpu_pend = !fpu_idle && fpu_we;

    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i_rs_used[i] &&
                (tag_hit(i_rs_idx[5*i +: 5], i_rs_fp[i], mul_pend, mul_rd, mul_rd_fp) ||
                 tag_hit(i_rs_idx[5*i +: 5], i_rs_fp[i], fpu_pend, fpu_rd, fpu_rd_fp))) begin
                raw = 1'b1;
            end
        end
    end

    assign waw = i_issue_reg_write &&
                 (tag_hit(i_issue_rd, i_issue_rd_fp, mul_pend, mul_rd, mul_rd_fp) ||
                  tag_hit(i_issue_rd, i_issue_rd_fp, fpu_pend, fpu_rd, fpu_rd_fp));
    assign unit_busy = ((i_issue_src == SRC_MUL) && !mul_idle) ||
                       ((i_issue_src == SRC_FPU) && !fpu_idle);

    assign o_issue_stall = i_issue_valid && (unit_busy || raw || waw);
    // live_q keeps launches quiet in the first cycle out of reset.
    assign launch        = live_q && i_issue_valid && !o_issue_stall && !i_flush;
    assign o_mul_start   = launch && (i_issue_src == SRC_MUL);
    assign o_fpu_start   = launch && (i_issue_src == SRC_FPU);

    // age_q set means the FPU was launched most recently, so the MUL is older.
    assign grant_fpu = fpu_hold && (!mul_hold || !age_q);
    assign grant_mul = mul_hold && !grant_fpu;

    always_comb begin
        o_wb_valid = mul_hold || fpu_hold;
        o_wb_rd    = '0;
        o_wb_fp    = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_data  = '0;
        if (grant_fpu) begin
            o_wb_rd   = fpu_rd;
            o_wb_fp   = fpu_rd_fp;
            o_wb_we   = fpu_we;
            o_wb_data = fpu_res;
        end else if (grant_mul) begin
            o_wb_rd   = mul_rd;
            o_wb_fp   = mul_rd_fp;
            o_wb_we   = mul_we;
            o_wb_data = mul_res;
        end
    end

    assign o_timeout = timeout_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_q    <= 1'b0;
            age_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (o_mul_start) begin
                age_q <= 1'b0;
            end else if (o_fpu_start) begin
                age_q <= 1'b1;
            end
            if (mul_to || fpu_to) timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_unit_sched.sv
// Directed bench for mc_unit_sched: a hazard vector table against two pending
// ops, plus hand-written sequences for writeback ordering, flush and timeout.
module tb_mc_unit_sched;
    import riscv_pkg::*;

    logic        clk, rst_n;
    logic        issue_valid, issue_rd_fp, issue_reg_write, flush;
    logic [2:0]  issue_src, rs_used, rs_fp;
    logic [4:0]  issue_rd;
    logic [14:0] rs_idx;
    logic        issue_stall, mul_start, mul_done, fpu_start, fpu_done;
    logic [31:0] mul_result, fpu_result, wb_data;
    logic        wb_ready, wb_valid, wb_fp, wb_we, timeout;
    logic [4:0]  wb_rd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  src;
        logic [4:0]  rd;
        logic        rd_fp;
        logic        rw;
        logic [14:0] rs;
        logic [2:0]  used;
        logic [2:0]  fp;
        logic        stall;
    } vec_t;

    vec_t vecs[13];

    mc_unit_sched #(.XLEN(32), .TIMEOUT_CYC(64)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_issue_valid    (issue_valid),
        .i_issue_src      (issue_src),
        .i_issue_rd       (issue_rd),
        .i_issue_rd_fp    (issue_rd_fp),
        .i_issue_reg_write(issue_reg_write),
        .i_rs_idx         (rs_idx),
        .i_rs_used        (rs_used),
        .i_rs_fp          (rs_fp),
        .i_flush          (flush),
        .o_issue_stall    (issue_stall),
        .o_mul_start      (mul_start),
        .i_mul_done       (mul_done),
        .i_mul_result     (mul_result),
        .o_fpu_start      (fpu_start),
        .i_fpu_done       (fpu_done),
        .i_fpu_result     (fpu_result),
        .i_wb_ready       (wb_ready),
        .o_wb_valid       (wb_valid),
        .o_wb_rd          (wb_rd),
        .o_wb_fp          (wb_fp),
        .o_wb_we          (wb_we),
        .o_wb_data        (wb_data),
        .o_timeout        (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        issue_valid     = 1'b0;
        issue_src       = SRC_ALU;
        issue_rd        = 5'd0;
        issue_rd_fp     = 1'b0;
        issue_reg_write = 1'b0;
        rs_idx          = 15'd0;
        rs_used         = 3'b000;
        rs_fp           = 3'b000;
        flush           = 1'b0;
    endtask

    task automatic set_issue(input logic [2:0] src, input logic [4:0] rd, input logic fp,
                             input logic we);
        issue_valid     = 1'b1;
        issue_src       = src;
        issue_rd        = rd;
        issue_rd_fp     = fp;
        issue_reg_write = we;
    endtask

    task automatic check_wb(input string name, input logic v, input logic [4:0] rd,
                            input logic fp, input logic we, input logic [31:0] d);
        check({name, "_valid"}, 32'(wb_valid), 32'(v));
        check({name, "_rd"}, 32'(wb_rd), 32'(rd));
        check({name, "_fp"}, 32'(wb_fp), 32'(fp));
        check({name, "_we"}, 32'(wb_we), 32'(we));
        check({name, "_data"}, wb_data, d);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_stall"}, 32'(issue_stall), 32'd0);
        check({name, "_mul_start"}, 32'(mul_start), 32'd0);
        check({name, "_fpu_start"}, 32'(fpu_start), 32'd0);
        check({name, "_timeout"}, 32'(timeout), 32'd0);
        check_wb(name, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // Issue an op expected to launch this cycle; returns one cycle later with issue cleared.
    task automatic launch(input string name, input logic [2:0] src, input logic [4:0] rd,
                          input logic fp, input logic we);
        set_issue(src, rd, fp, we);
        #1;
        check({name, "_stall"}, 32'(issue_stall), 32'd0);
        check({name, "_start"}, 32'((src == SRC_MUL) ? mul_start : fpu_start), 32'd1);
        tick();
        clear_issue();
    endtask

    initial begin
        rst_n      = 1'b0;
        clear_issue();
        mul_done   = 1'b0;
        fpu_done   = 1'b0;
        mul_result = 32'd0;
        fpu_result = 32'd0;
        wb_ready   = 1'b1;

        // Outputs quiet in reset and in the first cycle after it.
        set_issue(SRC_MUL, 5'd1, 1'b0, 1'b1);
        mul_done = 1'b1;
        fpu_done = 1'b1;
        #2;
        check_all_zero("in_reset");
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_all_zero("first_cycle");
        clear_issue();
        mul_done = 1'b0;
        fpu_done = 1'b0;
        tick();

        // Basic MUL: done three cycles after launch, writeback the next cycle.
        launch("mul_basic", SRC_MUL, 5'd5, 1'b0, 1'b1);
        #1;
        check("mul_start_pulse", 32'(mul_start), 32'd0);
        tick();
        tick();
        mul_done   = 1'b1;
        mul_result = 32'h0000_0036;
        #1;
        check("wb_same_cycle", 32'(wb_valid), 32'd0);
        tick();
        mul_done = 1'b0;
        #1;
        check_wb("mul_wb", 1'b1, 5'd5, 1'b0, 1'b1, 32'h36);
        set_issue(SRC_MUL, 5'd6, 1'b0, 1'b1);
        #1;
        check("mul_hold_unit_stall", 32'(issue_stall), 32'd1);
        clear_issue();
        tick();
        #1;
        check("mul_retired_valid", 32'(wb_valid), 32'd0);
        set_issue(SRC_MUL, 5'd6, 1'b0, 1'b1);
        #1;
        check("mul_idle_stall", 32'(issue_stall), 32'd0);
        check("mul_idle_start", 32'(mul_start), 32'd1);
        clear_issue();
        tick();

        // RAW stall holds through BUSY and HOLD until retirement.
        launch("raw_mul", SRC_MUL, 5'd5, 1'b0, 1'b1);
        set_issue(SRC_ALU, 5'd9, 1'b0, 1'b1);
        rs_idx  = {5'd0, 5'd0, 5'd5};
        rs_used = 3'b001;
        #1;
        check("raw_busy", 32'(issue_stall), 32'd1);
        tick();
        mul_done   = 1'b1;
        mul_result = 32'h11;
        #1;
        check("raw_done", 32'(issue_stall), 32'd1);
        tick();
        mul_done = 1'b0;
        wb_ready = 1'b0;
        #1;
        check("raw_hold", 32'(issue_stall), 32'd1);
        tick();
        check("raw_hold_data", wb_data, 32'h11);
        wb_ready = 1'b1;
        #1;
        check("raw_retiring", 32'(issue_stall), 32'd1);
        tick();
        check("raw_retired", 32'(issue_stall), 32'd0);
        clear_issue();

        // x0 is never pending, even when a unit targets it.
        launch("x0_mul", SRC_MUL, 5'd0, 1'b0, 1'b1);
        set_issue(SRC_ALU, 5'd0, 1'b0, 1'b1);
        rs_used = 3'b001;
        #1;
        check("x0_no_stall", 32'(issue_stall), 32'd0);
        clear_issue();
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        check_wb("x0_wb", 1'b1, 5'd0, 1'b0, 1'b1, 32'h11);
        tick();

        // Hazard table with MUL pending x5 and FPU pending f0.
        launch("tbl_mul", SRC_MUL, 5'd5, 1'b0, 1'b1);
        launch("tbl_fpu", SRC_FPU, 5'd0, 1'b1, 1'b1);
        vecs[0]  = '{1'b1, SRC_ALU, 5'd0, 1'b0, 1'b0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b000, 1'b1};
        vecs[1]  = '{1'b1, SRC_ALU, 5'd0, 1'b0, 1'b0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b001, 1'b0};
        vecs[2]  = '{1'b1, SRC_ALU, 5'd0, 1'b0, 1'b0, {5'd0, 5'd5, 5'd0}, 3'b010, 3'b000, 1'b1};
        vecs[3]  = '{1'b1, SRC_ALU, 5'd0, 1'b0, 1'b0, {5'd0, 5'd0, 5'd5}, 3'b000, 3'b000, 1'b0};
        vecs[4]  = '{1'b1, SRC_ALU, 5'd0, 1'b0, 1'b0, {5'd0, 5'd0, 5'd0}, 3'b100, 3'b100, 1'b1};
        vecs[5]  = '{1'b1, SRC_ALU, 5'd5, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 1'b1};
        vecs[6]  = '{1'b1, SRC_ALU, 5'd5, 1'b0, 1'b0, 15'd0, 3'b000, 3'b000, 1'b0};
        vecs[7]  = '{1'b1, SRC_ALU, 5'd0, 1'b1, 1'b1, 15'd0, 3'b000, 3'b000, 1'b1};
        vecs[8]  = '{1'b1, SRC_ALU, 5'd0, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 1'b0};
        vecs[9]  = '{1'b1, SRC_MUL, 5'd7, 1'b0, 1'b1, 15'd0, 3'b000, 3'b000, 1'b1};
        vecs[10] = '{1'b1, SRC_FPU, 5'd7, 1'b1, 1'b1, 15'd0, 3'b000, 3'b000, 1'b1};
        vecs[11] = '{1'b0, SRC_ALU, 5'd0, 1'b0, 1'b0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b000, 1'b0};
        vecs[12] = '{1'b1, SRC_ALU, 5'd0, 1'b0, 1'b0, {5'd4, 5'd4, 5'd4}, 3'b111, 3'b000, 1'b0};
        for (int i = 0; i < 13; i++) begin
            issue_valid     = vecs[i].valid;
            issue_src       = vecs[i].src;
            issue_rd        = vecs[i].rd;
            issue_rd_fp     = vecs[i].rd_fp;
            issue_reg_write = vecs[i].rw;
            rs_idx          = vecs[i].rs;
            rs_used         = vecs[i].used;
            rs_fp           = vecs[i].fp;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(issue_stall), 32'(vecs[i].stall));
            check($sformatf("vec%0d_mul_start", i), 32'(mul_start), 32'd0);
            check($sformatf("vec%0d_fpu_start", i), 32'(fpu_start), 32'd0);
            tick();
        end
        clear_issue();
        // Both done together: MUL launched first, so it retires first.
        mul_result = 32'h5555;
        fpu_result = 32'hF0F0;
        mul_done   = 1'b1;
        fpu_done   = 1'b1;
        tick();
        mul_done = 1'b0;
        fpu_done = 1'b0;
        check_wb("tbl_first", 1'b1, 5'd5, 1'b0, 1'b1, 32'h5555);
        tick();
        check_wb("tbl_second", 1'b1, 5'd0, 1'b1, 1'b1, 32'hF0F0);
        tick();
        check("tbl_drained", 32'(wb_valid), 32'd0);

        // FPU f2 first, MUL x3 second, both done together, writeback blocked 4 cycles.
        launch("ord_fpu", SRC_FPU, 5'd2, 1'b1, 1'b1);
        launch("ord_mul", SRC_MUL, 5'd3, 1'b0, 1'b1);
        fpu_result = 32'hAAAA_0002;
        mul_result = 32'hBBBB_0003;
        mul_done   = 1'b1;
        fpu_done   = 1'b1;
        wb_ready   = 1'b0;
        tick();
        mul_done   = 1'b0;
        fpu_done   = 1'b0;
        fpu_result = 32'd0;
        mul_result = 32'd0;
        for (int k = 0; k < 4; k++) begin
            check_wb($sformatf("ord_blocked%0d", k), 1'b1, 5'd2, 1'b1, 1'b1, 32'hAAAA_0002);
            tick();
        end
        wb_ready = 1'b1;
        #1;
        check_wb("ord_f2", 1'b1, 5'd2, 1'b1, 1'b1, 32'hAAAA_0002);
        tick();
        check_wb("ord_x3", 1'b1, 5'd3, 1'b0, 1'b1, 32'hBBBB_0003);
        tick();
        check("ord_drained", 32'(wb_valid), 32'd0);

        // Flush suppresses a launch but not an op already in flight.
        set_issue(SRC_FPU, 5'd4, 1'b1, 1'b1);
        flush = 1'b1;
        #1;
        check("flush_fpu_start", 32'(fpu_start), 32'd0);
        check("flush_stall", 32'(issue_stall), 32'd0);
        tick();
        clear_issue();
        launch("after_flush", SRC_FPU, 5'd7, 1'b1, 1'b1);
        set_issue(SRC_ALU, 5'd8, 1'b0, 1'b1);
        flush      = 1'b1;
        fpu_done   = 1'b1;
        fpu_result = 32'h77;
        tick();
        clear_issue();
        fpu_done = 1'b0;
        check_wb("flush_inflight", 1'b1, 5'd7, 1'b1, 1'b1, 32'h77);
        // Retire FPU while launching MUL in the same cycle.
        set_issue(SRC_MUL, 5'd9, 1'b0, 1'b1);
        #1;
        check("retire_launch_stall", 32'(issue_stall), 32'd0);
        check("retire_launch_start", 32'(mul_start), 32'd1);
        tick();
        clear_issue();
        check("retire_launch_drained", 32'(wb_valid), 32'd0);
        mul_done   = 1'b1;
        mul_result = 32'h99;
        tick();
        mul_done = 1'b0;
        check_wb("retire_launch_mul", 1'b1, 5'd9, 1'b0, 1'b1, 32'h99);
        tick();

        // Done on the final BUSY cycle beats the timeout.
        launch("edge_fpu", SRC_FPU, 5'd10, 1'b1, 1'b0);
        repeat (63) tick();
        fpu_done   = 1'b1;
        fpu_result = 32'hD0;
        tick();
        fpu_done = 1'b0;
        check("edge_no_timeout", 32'(timeout), 32'd0);
        check_wb("edge_wb", 1'b1, 5'd10, 1'b1, 1'b0, 32'hD0);
        tick();

        // MUL never completes: dropped after 64 BUSY cycles, timeout sticks.
        launch("to_mul", SRC_MUL, 5'd1, 1'b0, 1'b1);
        repeat (63) tick();
        check("to_before", 32'(timeout), 32'd0);
        tick();
        check("to_after", 32'(timeout), 32'd1);
        check("to_no_wb", 32'(wb_valid), 32'd0);
        set_issue(SRC_MUL, 5'd2, 1'b0, 1'b1);
        #1;
        check("to_relaunch_stall", 32'(issue_stall), 32'd0);
        check("to_relaunch_start", 32'(mul_start), 32'd1);
        tick();
        clear_issue();
        check("to_sticky", 32'(timeout), 32'd1);

        // Reset with units busy clears everything at once; early done is ignored.
        launch("rst_fpu", SRC_FPU, 5'd3, 1'b1, 1'b1);
        set_issue(SRC_MUL, 5'd4, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        rst_n    = 1'b1;
        fpu_done = 1'b1;
        mul_done = 1'b1;
        set_issue(SRC_FPU, 5'd4, 1'b1, 1'b1);
        #1;
        check_all_zero("rst_first_cycle");
        tick();
        clear_issue();
        fpu_done = 1'b0;
        mul_done = 1'b0;
        #1;
        check("rst_done_ignored", 32'(wb_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_unit_sched.md
Name: mc_unit_sched

Overview:
Issue/writeback scheduler for the core's two multi-cycle execution units: integer multiplier (SRC_MUL) and FPU (SRC_FPU).
- Sits between decode/execute and the units: launches ops, tracks one outstanding op per unit, and raises RAW/WAW interlock stalls.
- Arbitrates completed results onto the shared writeback port.
- Single-cycle sources (ALU, DMEM, PC+4, IMM, CSR) bypass this block.

Parameters:
XLEN, 32, datapath/result width
TIMEOUT_CYC, 64, max BUSY cycles before a unit op is abandoned

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_issue_valid  in  1  decoded instruction present in execute
i_issue_src  in  3  writeback source code (SRC_* encoding)
i_issue_rd  in  5  destination register index
i_issue_rd_fp  in  1  destination is FP register file
i_issue_reg_write  in  1  instruction writes a destination
i_rs_idx  in  15  {rs3,rs2,rs1} operand indices
i_rs_used  in  3  per-operand valid
i_rs_fp  in  3  per-operand is FP register
i_flush  in  1  kill the instruction currently in execute
o_issue_stall  out  1  hold execute stage (combinational)
o_mul_start  out  1  one-cycle launch pulse to multiplier
i_mul_done  in  1  multiplier result valid (one cycle)
i_mul_result  in  XLEN  multiplier result
o_fpu_start  out  1  one-cycle launch pulse to FPU
i_fpu_done  in  1  FPU result valid (one cycle)
i_fpu_result  in  XLEN  FPU result
i_wb_ready  in  1  shared writeback port free this cycle
o_wb_valid  out  1  scheduled result presented
o_wb_rd  out  5  writeback index
o_wb_fp  out  1  target FP file (else integer)
o_wb_we  out  1  reg_write of retiring op
o_wb_data  out  XLEN  writeback data
o_timeout  out  1  sticky: some unit exceeded TIMEOUT_CYC

Behaviour:
- Clock and reset: single clock i_clk; i_rst_n asynchronous, active-low.
- Reset: both slots IDLE, counters 0, age bit 0, o_timeout 0. All outputs 0 while in reset and in the first cycle after it.
- Per-unit slot FSM:
  - IDLE→BUSY on start: captures rd, rd_fp, reg_write; counter cleared.
  - BUSY→HOLD on done: result captured.
  - HOLD→IDLE when granted with i_wb_ready=1.
  - done in IDLE or HOLD is ignored.
- Timeout: BUSY counter increments each cycle. At TIMEOUT_CYC, slot→IDLE, op dropped, o_timeout set until reset. A done in the same cycle as the timeout wins (→HOLD, no timeout).
- Stall (combinational): o_issue_stall=1 when i_issue_valid and any of:
  - (a) i_issue_src targets a unit whose slot ≠ IDLE;
  - (b) a used operand matches the rd of a non-IDLE slot with reg_write=1 and the same file class;
  - (c) i_issue_rd matches such a pending rd in the same class and i_issue_reg_write=1 (WAW).
  - Integer x0 never matches; FP f0 does.
- Start: o_mul_start = i_issue_valid & src==SRC_MUL & !o_issue_stall & !i_flush; likewise o_fpu_start for SRC_FPU.
  - i_flush suppresses the launch only. In-flight slots are unaffected; they are older than the flushed instruction.
- Age: the age bit records which slot started most recently; the older of two HOLD slots is granted first. With one HOLD slot, that slot is granted.
- Writeback: o_wb_* are driven combinationally from the granted HOLD slot; o_wb_valid = any HOLD.
  - Retirement only when i_wb_ready=1; otherwise the slot stays in HOLD with data stable.
  - Minimum latency: done in cycle N → o_wb_valid in N+1.
- The slot returns to IDLE the cycle after retirement; a new start to the same unit is accepted from then. One bubble per back-to-back op to the same unit.
- Simultaneous events:
  - Retire and a new start to the other unit in the same cycle are both legal.
  - mul_done and fpu_done in the same cycle both capture.
- Pending-rd match compares 5-bit index plus class bit only; no partial-width compare.

Decomposition:
- Shared package riscv_pkg: SRC_* writeback-source codes (3 bits: ALU 0, DMEM 1, PC+4 2, IMM 3, CSR 4, MUL 5, FPU 6) and slot-state enum {IDLE, BUSY, HOLD}.
- One sub-module, mc_unit_slot, instantiated twice; the top adds hazard compare, start gating, age bit, and grant mux. It contains:
  - the slot FSM;
  - rd/class/we tag registers;
  - the result hold register;
  - the timeout counter.

Test Plan:
- MUL issue rd=x5, done 3 cycles later with 0x0000_0036, wb_ready=1 → o_mul_start 1 cycle; o_wb_valid/rd=5/fp=0/data=0x36 one cycle after done; slot IDLE next cycle.
- MUL pending rd=x5; issue ALU op with rs1=x5 → o_issue_stall=1 until the MUL retires; same op with rs1=x0 while MUL pending to x0 → no stall.
- FPU started first (rd=f2), MUL second (rd=x3); both done in the same cycle → f2 written first, x3 next cycle.
- Both slots in HOLD, wb_ready low 4 cycles → o_wb_valid held with stable data; first retirement on the cycle wb_ready rises.
- FPU issue with i_flush=1 → o_fpu_start=0 and no stall state; FPU in flight during flush → still retires normally.
- MUL started, no done for 64 cycles → o_timeout=1, slot IDLE, new MUL issue accepted. Reset asserted while FPU is BUSY → all outputs 0 immediately, and a done in the first cycle after reset produces no writeback.
